adder_selftest_driver: RTL and testbench

// - On-chip stimulus/check initiator for the 16-bit adder top level's button/switch interface.
// - Drives the active-low LoadB and Run pulses and the SW operand bus.
// - Steps through a fixed operand table and compares the returned {CO,Sum} against an internally computed A+B.
// - Reports pass/fail and the first failing vector, for board bring-up without a host.

---
 rtl/adder_selftest_driver.sv | 146 ++++++++++++++
 tb/tb_adder_selftest_driver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_selftest_driver.sv
// Self-test initiator for the 16-bit adder board top: drives LoadB/Run/SW and checks {CO,Sum} against A+B.
// Optional build macro SELFTEST_STOP_ON_FAIL_EN ends the pass at the first mismatching vector.
module adder_selftest_driver #(
  parameter int WIDTH         = 16,
  parameter int NUM_VEC       = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Sum,
  input  logic             CO,
  output logic [WIDTH-1:0] SW,
  output logic             LoadB,
  output logic             Run,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [3:0]       ErrCount,
  output logic [2:0]       FailIdx
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETB, S_LDB, S_SETA, S_RUN, S_WAIT, S_CHK, S_FIN
  } state_t;

  state_t          state, next_state;
  logic [2:0]      idx, idx_next;
  logic [CW-1:0]   settle_cnt;
  logic [WIDTH:0]  expected_sum;
  logic            mismatch;
  logic            last_vec;
  logic            settle_done;

  function automatic logic [WIDTH-1:0] op_a(input logic [2:0] i);
    case (i)
      3'd0:    op_a = WIDTH'(16'h0001);
      3'd1:    op_a = WIDTH'(16'hFFFF);
      3'd2:    op_a = WIDTH'(16'h8000);
      3'd3:    op_a = WIDTH'(16'h1234);
      3'd4:    op_a = WIDTH'(16'h0000);
      3'd5:    op_a = WIDTH'(16'hAAAA);
      3'd6:    op_a = WIDTH'(16'h7FFF);
      default: op_a = WIDTH'(16'hFFFF);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] op_b(input logic [2:0] i);
    case (i)
      3'd0:    op_b = WIDTH'(16'h0002);
      3'd1:    op_b = WIDTH'(16'h0001);
      3'd2:    op_b = WIDTH'(16'h8000);
      3'd3:    op_b = WIDTH'(16'h4321);
      3'd4:    op_b = WIDTH'(16'h0000);
      3'd5:    op_b = WIDTH'(16'h5555);
      3'd6:    op_b = WIDTH'(16'h0001);
      default: op_b = WIDTH'(16'hFFFF);
    endcase
  endfunction

  assign expected_sum = {1'b0, op_a(idx)} + {1'b0, op_b(idx)};
  assign mismatch     = ({CO, Sum} != expected_sum);
  assign last_vec     = (idx == 3'(NUM_VEC - 1));
  assign settle_done  = (settle_cnt == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    idx_next   = idx;
    case (state)
      S_IDLE: if (Start) begin
        next_state = S_SETB;
        idx_next   = '0;
      end
      S_SETB: next_state = S_LDB;
      S_LDB:  next_state = S_SETA;
      S_SETA: next_state = S_RUN;
      S_RUN:  next_state = S_WAIT;
      S_WAIT: if (settle_done) next_state = S_CHK;
      S_CHK: begin
`ifdef SELFTEST_STOP_ON_FAIL_EN
        if (mismatch || last_vec) next_state = S_FIN;
        else                      next_state = S_SETB;
`else
        if (last_vec) next_state = S_FIN;
        else          next_state = S_SETB;
`endif
        if (next_state == S_SETB) idx_next = idx + 3'd1;
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so the pin timing lines up with the state itself.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      SW         <= '0;
      LoadB      <= 1'b1;
      Run        <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Pass       <= 1'b0;
      ErrCount   <= '0;
      FailIdx    <= '0;
      idx        <= '0;
      settle_cnt <= '0;
    end else begin
      LoadB      <= (next_state != S_LDB);
      Run        <= (next_state != S_RUN);
      idx        <= idx_next;
      settle_cnt <= (state == S_WAIT) ? settle_cnt + 1'b1 : '0;
      case (next_state)
        S_SETB, S_LDB:                 SW <= op_b(idx_next);
        S_SETA, S_RUN, S_WAIT, S_CHK:  SW <= op_a(idx_next);
        default:                       SW <= '0;
      endcase
      case (state)
        S_IDLE: if (Start) begin
          Busy     <= 1'b1;
          Done     <= 1'b0;
          Pass     <= 1'b0;
          ErrCount <= '0;
          FailIdx  <= '0;
        end
        S_CHK: if (mismatch) begin
          if (ErrCount == 4'd0)  FailIdx  <= idx;
          if (ErrCount != 4'hF)  ErrCount <= ErrCount + 4'd1;
        end
        S_FIN: begin
          Busy <= 1'b0;
          Done <= 1'b1;
          Pass <= (ErrCount == 4'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_selftest_driver.sv
// Self-checking bench for adder_selftest_driver: behavioural adder model with injectable faults,
// a table of fixed fault cases, randomized corruption passes and hand-written reset/Start sequences.
module tb_adder_selftest_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] sum;
  logic        co;
  logic [15:0] sw;
  logic        load_b, run, busy, done, pass;
  logic [3:0]  err_count;
  logic [2:0]  fail_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] tb_a [8] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234, 16'h0000, 16'hAAAA, 16'h7FFF, 16'hFFFF};
  logic [15:0] tb_b [8] = '{16'h0002, 16'h0001, 16'h8000, 16'h4321, 16'h0000, 16'h5555, 16'h0001, 16'hFFFF};

  // fault modes: 0 ideal, 1 CO stuck 0, 2 Sum[15] stuck 1, 3 per-vector XOR corruption
  int          fault_mode = 0;
  logic [16:0] cmask [8];
  logic [15:0] model_a = '0;
  logic [15:0] model_b = '0;
  int          model_vec;
  logic [16:0] model_exact;
  logic [16:0] model_mask;

  logic [15:0] lb_q [$];
  logic [15:0] rn_q [$];
  int          both_low = 0;

  always #5 clk = ~clk;

  adder_selftest_driver dut (
    .clk(clk), .Reset(rst_n), .Start(start), .Sum(sum), .CO(co),
    .SW(sw), .LoadB(load_b), .Run(run), .Busy(busy), .Done(done),
    .Pass(pass), .ErrCount(err_count), .FailIdx(fail_idx)
  );

  function automatic int find_vec(input logic [15:0] a, input logic [15:0] b);
    for (int v = 0; v < 8; v++)
      if (tb_a[v] == a && tb_b[v] == b) return v;
    return -1;
  endfunction

  function automatic logic [16:0] apply_fault(input int mode, input logic [16:0] exact, input logic [16:0] mask);
    logic [16:0] r;
    r = exact;
    case (mode)
      1: r[16] = 1'b0;
      2: r[15] = 1'b1;
      3: r = r ^ mask;
      default: ;
    endcase
    return r;
  endfunction

  // Adder board model: B captured while LoadB is low, A while Run is low.
  always @(posedge clk) begin
    if (!load_b) model_b <= sw;
    if (!run)    model_a <= sw;
  end

  always_comb begin
    model_vec   = find_vec(model_a, model_b);
    model_mask  = (model_vec >= 0) ? cmask[model_vec] : 17'd0;
    model_exact = {1'b0, model_a} + {1'b0, model_b};
    {co, sum}   = apply_fault(fault_mode, model_exact, model_mask);
  end

  always @(negedge clk) begin
    if (!load_b) lb_q.push_back(sw);
    if (!run)    rn_q.push_back(sw);
    if (!load_b && !run) both_low = both_low + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Expected outcome of one pass, from the vector table and the fault rules.
  task automatic ref_model(input int mode, output int err, output int fail, output int pas,
                           output int ncyc, output int nvec);
    logic [16:0] exact, got;
    err  = 0;
    fail = 0;
    nvec = 8;
    for (int v = 0; v < 8; v++) begin
      exact = {1'b0, tb_a[v]} + {1'b0, tb_b[v]};
      got   = apply_fault(mode, exact, (mode == 3) ? cmask[v] : 17'd0);
      if (got != exact) begin
        if (err == 0) fail = v;
        if (err < 15) err++;
`ifdef SELFTEST_STOP_ON_FAIL_EN
        nvec = v + 1;
        break;
`endif
      end
    end
    pas  = (err == 0) ? 1 : 0;
    ncyc = 9 * nvec + 1;
  endtask

  task automatic run_and_check(input string tag, input int e_err, input int e_fail, input int e_pass,
                               input int e_cyc, input int e_nvec, input int pulse_at);
    int off_lb, off_rn, bl0, cycles;
    off_lb = lb_q.size();
    off_rn = rn_q.size();
    bl0    = both_low;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    check_val({tag, "_busy_start"}, 32'(busy), 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 300) begin
      start = (cycles == pulse_at);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check_val({tag, "_cycles"},   32'(cycles),    32'(e_cyc));
    check_val({tag, "_done"},     32'(done),      32'd1);
    check_val({tag, "_busy_end"}, 32'(busy),      32'd0);
    check_val({tag, "_pass"},     32'(pass),      32'(e_pass));
    check_val({tag, "_errcount"}, 32'(err_count), 32'(e_err));
    check_val({tag, "_failidx"},  32'(fail_idx),  32'(e_fail));
    check_val({tag, "_loadb_pulses"}, 32'(lb_q.size() - off_lb), 32'(e_nvec));
    check_val({tag, "_run_pulses"},   32'(rn_q.size() - off_rn), 32'(e_nvec));
    check_val({tag, "_both_low"},     32'(both_low - bl0),       32'd0);
    for (int v = 0; v < e_nvec && off_lb + v < lb_q.size() && off_rn + v < rn_q.size(); v++) begin
      check_val($sformatf("%s_sw_loadb%0d", tag, v), 32'(lb_q[off_lb + v]), 32'(tb_b[v]));
      check_val($sformatf("%s_sw_run%0d", tag, v),   32'(rn_q[off_rn + v]), 32'(tb_a[v]));
    end
  endtask

  typedef struct {
    int mode;
    int err;
    int fail;
    int pas;
  } vec_t;

  task automatic applyStimulus_dummy;
  endtask

  initial begin
    vec_t tbl [3];
    int r_err, r_fail, r_pass, r_cyc, r_nvec, cycles;

    tbl[0] = '{0, 0, 0, 1};
`ifdef SELFTEST_STOP_ON_FAIL_EN
    tbl[1] = '{1, 1, 1, 0};
    tbl[2] = '{2, 1, 0, 0};
`else
    tbl[1] = '{1, 3, 1, 0};
    tbl[2] = '{2, 5, 0, 0};
`endif
    for (int v = 0; v < 8; v++) cmask[v] = '0;

    rst_n = 1'b1;
    start = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_sw",       32'(sw),        32'd0);
    check_val("reset_loadb",    32'(load_b),    32'd1);
    check_val("reset_run",      32'(run),       32'd1);
    check_val("reset_busy",     32'(busy),      32'd0);
    check_val("reset_done",     32'(done),      32'd0);
    check_val("reset_pass",     32'(pass),      32'd0);
    check_val("reset_errcount", 32'(err_count), 32'd0);
    check_val("reset_failidx",  32'(fail_idx),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed fault table
    for (int t = 0; t < 3; t++) begin
      fault_mode = tbl[t].mode;
      ref_model(tbl[t].mode, r_err, r_fail, r_pass, r_cyc, r_nvec);
      run_and_check($sformatf("tbl%0d", t), tbl[t].err, tbl[t].fail, tbl[t].pas, r_cyc, r_nvec, -1);
    end

    // Randomized per-vector corruption against the reference model
    fault_mode = 3;
    for (int it = 0; it < 6; it++) begin
      for (int v = 0; v < 8; v++)
        cmask[v] = ($urandom_range(0, 1) == 1) ? 17'($urandom_range(1, 17'h1FFFF)) : 17'd0;
      ref_model(3, r_err, r_fail, r_pass, r_cyc, r_nvec);
      run_and_check($sformatf("rnd%0d", it), r_err, r_fail, r_pass, r_cyc, r_nvec, -1);
    end
    fault_mode = 0;
    for (int v = 0; v < 8; v++) cmask[v] = '0;

    // Start pulsed while busy must not disturb the pass
    run_and_check("start_busy", 0, 0, 1, 73, 8, 20);

    // Reset asserted in WAIT of vector 3
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check_val("pre_abort_busy", 32'(busy), 32'd1);
    check_val("pre_abort_sw",   32'(sw),   32'(tb_a[3]));
    rst_n = 1'b0;
    #1;
    check_val("abort_sw",       32'(sw),        32'd0);
    check_val("abort_loadb",    32'(load_b),    32'd1);
    check_val("abort_run",      32'(run),       32'd1);
    check_val("abort_busy",     32'(busy),      32'd0);
    check_val("abort_done",     32'(done),      32'd0);
    check_val("abort_pass",     32'(pass),      32'd0);
    check_val("abort_errcount", 32'(err_count), 32'd0);
    check_val("abort_failidx",  32'(fail_idx),  32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_and_check("after_abort", 0, 0, 1, 73, 8, -1);

    // Start held high through FIN starts a second pass right away
    start = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (done !== 1'b1 && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_val("hold_first_cycles", 32'(cycles), 32'd73);
    check_val("hold_first_pass",   32'(pass),   32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("hold_second_done_cleared", 32'(done), 32'd0);
    check_val("hold_second_busy",         32'(busy), 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
    end
    check_val("hold_second_cycles", 32'(cycles), 32'd73);
    check_val("hold_second_pass",   32'(pass),   32'd1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
